// File: rtl/uart_parameters.sv
// Shared UART link settings and the transmitter state encoding.
// The receiver imports the same package so both ends agree on framing.
package uart_parameters;

    localparam int CLOCK_FREQ = 50_000_000;
    localparam int BAUD_RATE  = 115_200;
    localparam int WORD_SIZE  = 8;

    function automatic int calc_bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    localparam int BIT_CYCLES = calc_bit_cycles(CLOCK_FREQ, BAUD_RATE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts clocks while enabled and flags the last clock of each bit.
// Held at zero while disabled, so every enable starts a full bit period.
module uart_baud_gen #(
    parameter int BIT_CYCLES = uart_parameters::BIT_CYCLES,
    parameter int CNT_W      = $clog2(BIT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    output logic o_bit_tick
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last     = (r_count == LAST_COUNT);
    assign o_bit_tick = i_enable && w_last;

    always_ff @(posedge clk) begin
        if (rst || !i_enable) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one-word holding register feeding an MSB-first shift register,
// framed as start bit, WORD_SIZE data bits, stop bit.
//
// state | meaning
// IDLE  | line high, waiting for a held word
// START | driving the start bit (0)
// DATA  | driving shift MSB, bit index counts up
// STOP  | driving the stop bit (1), frame_done on its last clock
module uart_transmitter #(
    parameter int WORD_SIZE  = uart_parameters::WORD_SIZE,
    parameter int CLOCK_FREQ = uart_parameters::CLOCK_FREQ,
    parameter int BAUD_RATE  = uart_parameters::BAUD_RATE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [WORD_SIZE-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    import uart_parameters::*;

    localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int IDX_W      = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_SIZE - 1);

    tx_state_t            r_state;
    logic [WORD_SIZE-1:0] r_hold;
    logic                 r_hold_full;
    logic [WORD_SIZE-1:0] r_shift;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_tx;
    logic                 r_busy;

    logic                 w_bit_tick;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_baud_en;
    logic [WORD_SIZE-1:0] w_shift_next;

    uart_baud_gen #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_baud_gen (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (w_baud_en),
        .o_bit_tick (w_bit_tick)
    );

    assign tx_ready     = !r_hold_full;
    assign w_accept     = tx_valid && !r_hold_full;
    assign w_baud_en    = (r_state != IDLE);
    assign w_shift_next = r_shift << 1;
    // The shifter only takes the held word when idle or at the very end of a stop bit.
    assign w_load       = r_hold_full &&
                          ((r_state == IDLE) || ((r_state == STOP) && w_bit_tick));

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = (r_state == STOP) && w_bit_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    // tx and busy are registered, so each branch sets them for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_load) begin
                        r_shift <= r_hold;
                        r_state <= START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_tick) begin
                        r_state   <= DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[WORD_SIZE-1];
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_idx == LAST_IDX) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_shift   <= w_shift_next;
                            r_tx      <= w_shift_next[WORD_SIZE-1];
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (w_bit_tick) begin
                        if (w_load) begin
                            r_shift <= r_hold;
                            r_state <= START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at BIT_CYCLES=10: reset/handshake vector table,
// then frame sequences checked cycle by cycle against a frame timing model and a serial decoder.
module tb_uart_transmitter;

    logic       clk;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    uart_transmitter #(
        .WORD_SIZE  (8),
        .CLOCK_FREQ (1_000_000),
        .BAUD_RATE  (100_000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected frames: start reference S (start bit at S+2), handshake cycle, holding-register load cycle.
    int         f_n = 0;
    int         f_start [3];
    int         f_hs    [3];
    int         f_ld    [3];
    logic [7:0] f_word  [3];

    // Independent serial decoder sampling mid-bit.
    logic [7:0] rx_q [$];
    logic [7:0] rx_sh;
    int         rx_t;
    logic       rx_act = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx == 1'b0) begin
                rx_act = 1'b1;
                rx_t   = 0;
            end
        end else begin
            rx_t = rx_t + 1;
            if (rx_t >= 15 && rx_t <= 85 && (rx_t % 10) == 5)
                rx_sh = {rx_sh[6:0], tx};
            if (rx_t == 95) begin
                rx_act = 1'b0;
                if (tx) rx_q.push_back(rx_sh);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Returns {tx, busy, frame_done, tx_ready} for cycle c.
    function automatic logic [3:0] expect_at(input int c);
        logic t = 1'b1;
        logic b = 1'b0;
        logic f = 1'b0;
        logic r = 1'b1;
        int   k;
        for (int i = 0; i < f_n; i++) begin
            if (c >= f_hs[i] + 1 && c <= f_ld[i]) r = 1'b0;
            k = c - f_start[i];
            if (k >= 2 && k <= 101) begin
                b = 1'b1;
                if (k < 12)      t = 1'b0;
                else if (k < 92) t = f_word[i][7 - (k - 12) / 10];
                else             t = 1'b1;
                if (k == 101)    f = 1'b1;
            end
        end
        return {t, b, f, r};
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Sends n words (valid dropped for gap cycles between words, held high when gap=0)
    // while checking every cycle against the model; shifter must be idle on entry.
    task automatic stream(input int n, input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input int gap);
        logic [7:0] w [3];
        int         n0;
        int         c_end;
        w  = '{w0, w1, w2};
        n0 = cyc;
        for (int i = 0; i < n; i++) begin
            f_word[i] = w[i];
            if (i == 0) begin
                f_hs[i] = n0;
                f_ld[i] = n0 + 1;
            end else begin
                f_hs[i] = imax(f_hs[i-1] + 1 + gap, f_ld[i-1] + 1);
                f_ld[i] = imax(f_hs[i] + 1, f_start[i-1] + 101);
            end
            f_start[i] = f_ld[i] - 1;
        end
        f_n   = n;
        c_end = f_start[n-1] + 104;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    int t;
                    if (i > 0 && gap > 0) begin
                        tx_valid = 1'b0;
                        repeat (gap) begin @(posedge clk); #1; end
                    end
                    tx_valid = 1'b1;
                    tx_data  = w[i];
                    t = 0;
                    while (!tx_ready && t < 400) begin
                        @(posedge clk); #1;
                        t++;
                    end
                    chk("handshake_cycle", cyc, f_hs[i]);
                    @(posedge clk); #1;
                    tx_data = ~w[i];
                end
                tx_valid = 1'b0;
            end
            begin
                for (int c = n0 + 1; c <= c_end; c++) begin
                    @(posedge clk); #1;
                    chk("line_state", {tx, busy, frame_done, tx_ready}, expect_at(cyc));
                end
            end
        join
    endtask

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [7];
    int   n_hs;

    initial begin
        // {tx, busy, frame_done, tx_ready} after the edge that samples the inputs
        vecs[0] = '{1'b1, 1'b1, 8'hAA, 4'b1001};
        vecs[1] = '{1'b1, 1'b1, 8'hAA, 4'b1001};
        vecs[2] = '{1'b0, 1'b1, 8'h5A, 4'b1000};
        vecs[3] = '{1'b0, 1'b1, 8'h11, 4'b0101};
        vecs[4] = '{1'b0, 1'b0, 8'h22, 4'b0101};
        vecs[5] = '{1'b1, 1'b1, 8'h33, 4'b1001};
        vecs[6] = '{1'b0, 1'b0, 8'h44, 4'b1001};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        for (int i = 0; i < 7; i++) begin
            rst      = vecs[i].rst;
            tx_valid = vecs[i].valid;
            tx_data  = vecs[i].data;
            @(posedge clk); #1;
            chk($sformatf("vector_%0d", i), {tx, busy, frame_done, tx_ready}, vecs[i].exp);
        end
        tx_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // single word
        rx_q.delete();
        stream(1, 8'hA5, 8'h00, 8'h00, 0);
        chk("single_rx_count", rx_q.size(), 1);
        if (rx_q.size() >= 1) chk("single_rx_word", rx_q[0], 8'hA5);

        // back-to-back, second word accepted mid-frame
        stream(2, 8'h00, 8'hFF, 8'h00, 30);

        // backpressure / loopback: valid held high across three words
        rx_q.delete();
        stream(3, 8'h3C, 8'hC3, 8'h96, 0);
        chk("loop_rx_count", rx_q.size(), 3);
        if (rx_q.size() >= 3) begin
            chk("loop_rx_word0", rx_q[0], 8'h3C);
            chk("loop_rx_word1", rx_q[1], 8'hC3);
            chk("loop_rx_word2", rx_q[2], 8'h96);
        end

        // reset during data bit 3 of 0x5A
        f_n        = 1;
        f_word[0]  = 8'h5A;
        f_start[0] = cyc;
        f_hs[0]    = cyc;
        f_ld[0]    = cyc + 1;
        n_hs       = cyc;
        tx_valid   = 1'b1;
        tx_data    = 8'h5A;
        @(posedge clk); #1;
        tx_valid   = 1'b0;
        chk("rst_frame", {tx, busy, frame_done, tx_ready}, expect_at(cyc));
        while (cyc < n_hs + 45) begin
            @(posedge clk); #1;
            chk("rst_frame", {tx, busy, frame_done, tx_ready}, expect_at(cyc));
        end
        rst      = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h77;
        @(posedge clk); #1;
        chk("rst_abort", {tx, busy, frame_done, tx_ready}, 4'b1001);
        rst      = 1'b0;
        tx_valid = 1'b0;
        f_n      = 0;
        rx_q.delete();
        repeat (12) begin
            @(posedge clk); #1;
            chk("post_rst_idle", {tx, busy, frame_done, tx_ready}, expect_at(cyc));
        end
        stream(1, 8'h81, 8'h00, 8'h00, 0);
        chk("post_rst_rx_count", rx_q.size(), 1);
        if (rx_q.size() >= 1) chk("post_rst_rx_word", rx_q[0], 8'h81);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
